// File: rtl/uart_rx_edge_bit_sampler.sv
// UART RX oversampling front end: 2-flop line synchroniser, per-bit edge counter,
// frame bit counter and a 3-sample mid-bit majority vote.
module uart_rx_edge_bit_sampler #(
    parameter int unsigned Data_Width = 8,
    parameter int unsigned B_C_W      = $clog2(Data_Width + 4)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RX_In,
    input  logic [5:0]       Prescale,
    input  logic             edge_bit_en,
    input  logic             data_samp_en,
    output logic             RX_Sync,
    output logic [5:0]       edge_count,
    output logic [B_C_W-1:0] Bit_Count,
    output logic             sampled_bit,
    output logic             sample_valid
);

    logic             r_sync1;
    logic             r_sync2;
    logic [5:0]       r_edge_count;
    logic [B_C_W-1:0] r_bit_count;
    logic             r_s0;
    logic             r_s1;
    logic             r_sampled_bit;
    logic             r_sample_valid;

    logic [5:0]       w_final;
    logic [5:0]       w_mid;
    logic [5:0]       w_mid_m1;
    logic [5:0]       w_mid_p1;
    logic             w_wrap;
    logic             w_samp_act;
    logic             w_majority;
    logic [5:0]       w_edge_d;
    logic [B_C_W-1:0] w_bit_d;

    // Sampling points derived from the oversampling ratio, all 6-bit modular.
    assign w_final  = Prescale - 6'd1;
    assign w_mid    = Prescale >> 1;
    assign w_mid_m1 = w_mid - 6'd1;
    assign w_mid_p1 = w_mid + 6'd1;

    // Prescale=0 makes Final wrap to 63; force a wrap every cycle so it behaves like 1.
    assign w_wrap     = (r_edge_count >= w_final) || (Prescale == 6'd0);
    assign w_samp_act = data_samp_en & edge_bit_en;
    assign w_majority = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RX_In;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state for the edge and bit counters; a disabled counter clears, even on a wrap.
    always_comb begin
        w_edge_d = r_edge_count;
        w_bit_d  = r_bit_count;
        if (!edge_bit_en) begin
            w_edge_d = 6'd0;
            w_bit_d  = '0;
        end else if (w_wrap) begin
            w_edge_d = 6'd0;
            if (r_bit_count != {B_C_W{1'b1}}) begin
                w_bit_d = r_bit_count + {{(B_C_W-1){1'b0}}, 1'b1};
            end
        end else begin
            w_edge_d = r_edge_count + 6'd1;
        end
    end

    // Counter state registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge_count <= 6'd0;
            r_bit_count  <= '0;
        end else begin
            r_edge_count <= w_edge_d;
            r_bit_count  <= w_bit_d;
        end
    end

    // Mid-bit sampler: capture two samples, then vote with the third and strobe valid.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s0           <= 1'b0;
            r_s1           <= 1'b0;
            r_sampled_bit  <= 1'b0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            if (w_samp_act) begin
                if (r_edge_count == w_mid_m1) begin
                    r_s0 <= r_sync2;
                end
                if (r_edge_count == w_mid) begin
                    r_s1 <= r_sync2;
                end
                if (r_edge_count == w_mid_p1) begin
                    r_sampled_bit  <= w_majority;
                    r_sample_valid <= 1'b1;
                end
            end
        end
    end

    assign RX_Sync      = r_sync2;
    assign edge_count   = r_edge_count;
    assign Bit_Count    = r_bit_count;
    assign sampled_bit  = r_sampled_bit;
    assign sample_valid = r_sample_valid;

endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// Self-checking bench for uart_rx_edge_bit_sampler: counter vector table, vote table,
// full 8N1 frame and reset corner cases, with a scoreboard for sample strobes.
module tb_uart_rx_edge_bit_sampler;

    logic       CLK;
    logic       RST;
    logic       RX_In;
    logic [5:0] Prescale;
    logic       edge_bit_en;
    logic       data_samp_en;
    logic       RX_Sync;
    logic [5:0] edge_count;
    logic [3:0] Bit_Count;
    logic       sampled_bit;
    logic       sample_valid;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [5:0] presc;
        int         n;
        logic [5:0] exp_edge;
        logic [3:0] exp_bit;
    } cnt_vec_t;

    typedef struct {
        logic v7;
        logic v8;
        logic v9;
        logic exp;
    } vote_vec_t;

    typedef struct {
        logic       bit_v;
        logic [3:0] idx;
        logic [5:0] at_edge;
    } sb_t;

    sb_t  sb_q[$];
    logic plan[0:511];

    uart_rx_edge_bit_sampler #(
        .Data_Width(8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_In       (RX_In),
        .Prescale    (Prescale),
        .edge_bit_en (edge_bit_en),
        .data_samp_en(data_samp_en),
        .RX_Sync     (RX_Sync),
        .edge_count  (edge_count),
        .Bit_Count   (Bit_Count),
        .sampled_bit (sampled_bit),
        .sample_valid(sample_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (sample_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_sample_valid", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("sb_sampled_bit", {31'd0, sampled_bit}, {31'd0, e.bit_v});
                check("sb_edge_at_valid", {26'd0, edge_count}, {26'd0, e.at_edge});
                check("sb_bit_at_valid", {28'd0, Bit_Count}, {28'd0, e.idx});
            end
        end
    end

    // Drive plan[k] onto RX_Sync in enabled cycle k, leading RX_In by the 2-flop delay.
    task automatic run_plan(input int n);
        edge_bit_en = 1'b0;
        RX_In = plan[0];
        repeat (2) @(posedge CLK);
        #1;
        RX_In = plan[1];
        @(posedge CLK);
        #1;
        edge_bit_en = 1'b1;
        for (int k = 0; k < n; k++) begin
            RX_In = (k + 2 < n) ? plan[k+2] : plan[n-1];
            @(posedge CLK);
            #1;
        end
        edge_bit_en = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_count(input cnt_vec_t v);
        data_samp_en = 1'b0;
        edge_bit_en  = 1'b0;
        @(posedge CLK);
        #1;
        Prescale    = v.presc;
        edge_bit_en = 1'b1;
        repeat (v.n) @(posedge CLK);
        #1;
        check($sformatf("cnt_edge_p%0d_n%0d", v.presc, v.n), {26'd0, edge_count},
              {26'd0, v.exp_edge});
        check($sformatf("cnt_bit_p%0d_n%0d", v.presc, v.n), {28'd0, Bit_Count},
              {28'd0, v.exp_bit});
        edge_bit_en = 1'b0;
    endtask

    initial begin
        cnt_vec_t  cnt_tbl[9];
        vote_vec_t vote_tbl[4];
        logic [7:0] byte_v;
        logic       frame_bits[10];

        cnt_tbl[0] = '{6'd8,  80,  6'd0, 4'd10};
        cnt_tbl[1] = '{6'd8,  13,  6'd5, 4'd1};
        cnt_tbl[2] = '{6'd16, 37,  6'd5, 4'd2};
        cnt_tbl[3] = '{6'd32, 100, 6'd4, 4'd3};
        cnt_tbl[4] = '{6'd1,  5,   6'd0, 4'd5};
        cnt_tbl[5] = '{6'd0,  7,   6'd0, 4'd7};
        cnt_tbl[6] = '{6'd5,  12,  6'd2, 4'd2};
        cnt_tbl[7] = '{6'd8,  200, 6'd0, 4'd15};
        cnt_tbl[8] = '{6'd2,  3,   6'd1, 4'd1};

        vote_tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1};
        vote_tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
        vote_tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vote_tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0};

        // Reset held: line toggling must not disturb anything.
        RST          = 1'b0;
        RX_In        = 1'b1;
        Prescale     = 6'd8;
        edge_bit_en  = 1'b0;
        data_samp_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            #1;
            RX_In = ~RX_In;
        end
        check("rst_rx_sync", {31'd0, RX_Sync}, 32'd1);
        check("rst_edge_count", {26'd0, edge_count}, 32'd0);
        check("rst_bit_count", {28'd0, Bit_Count}, 32'd0);
        check("rst_sampled_bit", {31'd0, sampled_bit}, 32'd0);
        check("rst_sample_valid", {31'd0, sample_valid}, 32'd0);

        RX_In = 1'b1;
        #2;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;

        // Synchroniser latency: two edges.
        RX_In = 1'b0;
        @(posedge CLK);
        #1;
        check("sync_after_1_edge", {31'd0, RX_Sync}, 32'd1);
        @(posedge CLK);
        #1;
        check("sync_after_2_edges", {31'd0, RX_Sync}, 32'd0);
        RX_In = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // Counter vectors.
        foreach (cnt_tbl[i]) run_count(cnt_tbl[i]);

        // Cycle-by-cycle wrap at Prescale=8, then the enable drop clears both.
        edge_bit_en = 1'b0;
        @(posedge CLK);
        #1;
        Prescale    = 6'd8;
        edge_bit_en = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(posedge CLK);
            #1;
            check("seq_edge_p8", {26'd0, edge_count}, i % 8);
        end
        check("seq_bit_p8_80", {28'd0, Bit_Count}, 32'd10);
        edge_bit_en = 1'b0;
        @(posedge CLK);
        #1;
        check("drop_clear_edge", {26'd0, edge_count}, 32'd0);
        check("drop_clear_bit", {28'd0, Bit_Count}, 32'd0);

        // Enable drops on the same edge that would wrap: clear wins.
        edge_bit_en = 1'b1;
        repeat (7) @(posedge CLK);
        #1;
        edge_bit_en = 1'b0;
        @(posedge CLK);
        #1;
        check("clear_wins_edge", {26'd0, edge_count}, 32'd0);
        check("clear_wins_bit", {28'd0, Bit_Count}, 32'd0);

        // Prescale lowered mid-bit past the current edge: wraps on the next edge.
        Prescale    = 6'd16;
        edge_bit_en = 1'b1;
        repeat (12) @(posedge CLK);
        #1;
        Prescale = 6'd8;
        @(posedge CLK);
        #1;
        check("presc_lowered_edge", {26'd0, edge_count}, 32'd0);
        check("presc_lowered_bit", {28'd0, Bit_Count}, 32'd1);
        edge_bit_en = 1'b0;
        @(posedge CLK);
        #1;

        // Majority vote patterns at Prescale=16.
        Prescale     = 6'd16;
        data_samp_en = 1'b1;
        foreach (vote_tbl[i]) begin
            for (int k = 0; k < 16; k++) plan[k] = 1'b1;
            plan[7] = vote_tbl[i].v7;
            plan[8] = vote_tbl[i].v8;
            plan[9] = vote_tbl[i].v9;
            sb_q.push_back('{vote_tbl[i].exp, 4'd0, 6'd10});
            run_plan(16);
            check("vote_sb_drained", sb_q.size(), 32'd0);
        end

        // Full 8N1 frame 0xA5 at Prescale=32.
        Prescale = 6'd32;
        byte_v   = 8'hA5;
        frame_bits[0] = 1'b0;
        for (int b = 0; b < 8; b++) frame_bits[b+1] = byte_v[b];
        frame_bits[9] = 1'b1;
        for (int k = 0; k < 320; k++) plan[k] = frame_bits[k/32];
        for (int b = 0; b < 10; b++) sb_q.push_back('{frame_bits[b], b[3:0], 6'd18});
        run_plan(320);
        check("frame_sb_drained", sb_q.size(), 32'd0);

        // Sampling disabled: counters run, no strobe, sampled_bit keeps the stop bit.
        Prescale     = 6'd16;
        data_samp_en = 1'b0;
        for (int k = 0; k < 24; k++) plan[k] = 1'b0;
        run_plan(24);
        check("nosamp_hold_bit", {31'd0, sampled_bit}, 32'd1);
        edge_bit_en = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        check("nosamp_counts_edge", {26'd0, edge_count}, 32'd4);
        check("nosamp_counts_bit", {28'd0, Bit_Count}, 32'd1);
        edge_bit_en = 1'b0;
        @(posedge CLK);
        #1;

        // Mid-frame asynchronous reset at bit 4, edge 5.
        Prescale     = 6'd8;
        RX_In        = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        data_samp_en = 1'b1;
        edge_bit_en  = 1'b1;
        for (int b = 0; b < 4; b++) sb_q.push_back('{1'b1, b[3:0], 6'd6});
        repeat (37) @(posedge CLK);
        #1;
        check("pre_rst_edge", {26'd0, edge_count}, 32'd5);
        check("pre_rst_bit", {28'd0, Bit_Count}, 32'd4);
        check("pre_rst_sampled", {31'd0, sampled_bit}, 32'd1);
        RX_In = 1'b0;
        #1;
        check("pre_rst_sync_low", {31'd0, RX_Sync}, 32'd1);
        #1;
        RST = 1'b0;
        #1;
        check("async_rst_edge", {26'd0, edge_count}, 32'd0);
        check("async_rst_bit", {28'd0, Bit_Count}, 32'd0);
        check("async_rst_sampled", {31'd0, sampled_bit}, 32'd0);
        check("async_rst_valid", {31'd0, sample_valid}, 32'd0);
        check("async_rst_sync", {31'd0, RX_Sync}, 32'd1);
        edge_bit_en  = 1'b0;
        data_samp_en = 1'b0;
        RX_In        = 1'b1;
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        edge_bit_en = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("post_rst_edge", {26'd0, edge_count}, 32'd3);
        check("post_rst_bit", {28'd0, Bit_Count}, 32'd0);
        edge_bit_en = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("final_sb_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
